fifo_ctrl_v2: RTL
=================

Name: fifo_ctrl_v2

Overview:
Parametrised synchronous FIFO, successor to the single-mode FIFO block. Uses full depth (no sacrificed slot) and adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and synchronous flush. Selectable standard (registered read) or first-word-fall-through (FWFT) read mode. Sits between producer and consumer blocks in the same clock domain.

Parameters:
DATA_WIDTH, 8, data word width in bits
FIFO_DEPTH, 16, number of entries; power of 2, >= 4
ADDR_WIDTH, $clog2(FIFO_DEPTH), storage address width; pointers are ADDR_WIDTH+1 bits
AF_LEVEL, FIFO_DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of pointers, count and data_valid
clear_err  in  1  synchronous clear of overflow/underflow
data_in  in  DATA_WIDTH  write data
Wr_enable  in  1  write request
Read_enable  in  1  read request (pop)
data_out  out  DATA_WIDTH  read data
data_valid  out  1  data_out holds a freshly popped word (standard mode); equals ~empty (FWFT)
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (reset==0, asynchronous assert): write_ptr=0, read_ptr=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0. Storage is not cleared. Reset mid-operation discards all contents immediately; deassertion takes effect at the next rising clock edge.
- Pointers are ADDR_WIDTH+1 bits; full when addresses are equal and MSBs differ; empty when pointers are equal. Wrap-around modulo 2*FIFO_DEPTH is natural.
- Write accepted iff Wr_enable && !full: mem[write_ptr[ADDR_WIDTH-1:0]] <= data_in; write_ptr++.
- Read accepted iff Read_enable && !empty: read_ptr++.
- Full and read+write in the same cycle: read accepted, write rejected, overflow set. Empty and read+write: write accepted, read rejected, underflow set. Otherwise simultaneous accepted read and write leave count unchanged.
- count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds FIFO_DEPTH or goes below 0.
- All flags combinational from count/pointers, valid in the cycle after the updating edge.
- Standard mode (FWFT=0): on an accepted read, data_out <= head word and data_valid=1 for one cycle (1-cycle latency); data_out holds its value otherwise; data_valid=0 on cycles without an accepted read.
- FWFT mode (FWFT=1): data_out = mem[read_ptr] combinationally; head visible while !empty; Read_enable acknowledges and pops; data_valid = ~empty. A word written into an empty FIFO appears on data_out one cycle after its write edge.
- overflow/underflow: set on a rejected write/read, hold until clear_err or reset; a set event in the same cycle as clear_err wins (flag stays 1).
- flush: pointers=0, count=0, data_valid=0 next edge; any write or read in the same cycle is ignored; error flags unaffected.
- Priority: reset > flush > read/write.

Decomposition:
- FIFO_pkg: add DATA_WIDTH/FIFO_DEPTH defaults, derived ADDR_WIDTH, a ptr_t typedef (ADDR_WIDTH+1 bits) and a read-mode enum (STD, FWFT).
- Sub-module fifo_mem_2p: simple dual-port register array (one write port, one asynchronous read port), no reset. The controller owns pointers, count, flags and the data_out register.

Test Plan:
- Reset then 16 writes of 0x00..0x0F (DEPTH=16) -> full=1 after the 16th edge, count=16, almost_full from count=14; a 17th write sets overflow=1 and leaves contents unchanged.
- Standard mode: write 0xA5, 0x3C, then read twice -> data_out=0xA5 with data_valid=1 one cycle after the first read, then 0x3C; a third read gives underflow=1 and data_out stays 0x3C.
- FWFT mode: write 0x7E into an empty FIFO -> data_out=0x7E and data_valid=1 one cycle later with no read; after Read_enable, empty=1 and data_valid=0.
- Wrap-around: 30 interleaved write/read pairs with count held at 3 -> data order preserved across the pointer wrap; count stays 3.
- Simultaneous read+write when full (count=16) -> count=15, overflow=1; when empty -> count=1, underflow=1; clear_err -> both flags 0.
- Reset asserted mid-burst at count=9, and flush at count=5 -> count=0, empty=1, data_valid=0; overflow retained after flush, cleared after reset.

Source files
------------

// File: rtl/fifo_ctrl_v2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl_v2_pkg
//  Description : Shared defaults, pointer type and read-mode encoding for the
//                fifo_ctrl_v2 FIFO controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_ctrl_v2_pkg;

    localparam int c_DATA_WIDTH = 8;
    localparam int c_FIFO_DEPTH = 16;
    localparam int c_ADDR_WIDTH = $clog2(c_FIFO_DEPTH);

    // One extra MSB distinguishes full from empty when the addresses match
    typedef logic [c_ADDR_WIDTH:0] ptr_t;

    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } read_mode_e;

    // Maps the integer FWFT parameter onto the read-mode enum
    function automatic read_mode_e mode_from_param(input int fwft);
        return (fwft != 0) ? RD_FWFT : RD_STD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem_2p
//  Description : Simple dual-port register array: one synchronous write port,
//                one asynchronous read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Store the write word; no reset so the array maps onto plain registers/RAM
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl_v2
//  Description : Full-depth synchronous FIFO with occupancy count, almost
//                flags, sticky overflow/underflow, synchronous flush and
//                selectable standard / first-word-fall-through read.
//  Revision    : 2.0 - count, almost flags, error flags, flush, FWFT mode
// ============================================================================
module fifo_ctrl_v2
    import fifo_ctrl_v2_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clear_err,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  Wr_enable,
    input  logic                  Read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] c_ONE   = (ADDR_WIDTH+1)'(1);
    localparam read_mode_e          c_MODE  = mode_from_param(FWFT);

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_wr_rej;
    logic                  w_rd_rej;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Full: same slot, opposite lap. Empty: pointers identical.
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Flush overrides any transfer in the same cycle and never raises errors
    assign w_wr_acc = Wr_enable   & ~w_full  & ~flush;
    assign w_rd_acc = Read_enable & ~w_empty & ~flush;
    assign w_wr_rej = Wr_enable   &  w_full  & ~flush;
    assign w_rd_rej = Read_enable &  w_empty & ~flush;

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rd_data)
    );

    // Advance pointers and occupancy on accepted transfers; flush rewinds all
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_wr_rej | (r_overflow  & ~clear_err);
            r_underflow <= w_rd_rej | (r_underflow & ~clear_err);
        end
    end

    generate
        if (c_MODE == RD_FWFT) begin : g_fwft
            // Head word is presented directly from storage while not empty
            assign data_out   = w_rd_data;
            assign data_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            logic                  r_data_valid;

            // Capture the popped head word; valid pulses for one cycle per pop
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else begin
                    r_data_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_data_out <= w_rd_data;
                    end
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
